// File: rtl/axi_lite_regtest_master.sv
`timescale 1ns/1ps
// AXI4-Lite register tester: for each register it writes a pattern word, reads
// it back and compares. It counts errors and records the first failing index.
// Every handshake wait is bounded by TIMEOUT_CYCLES.
module axi_lite_regtest_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              start,
  input  logic [1:0]                        pattern_mode,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     seed,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              timeout,
  output logic [7:0]                        err_count,
  output logic [7:0]                        first_err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int BW = $clog2(DW);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD, S_RD_DATA, S_CHECK, S_NEXT, S_FIN
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      idx;
  logic [DW-1:0]   seed_q, rdata_q, pattern;
  logic [1:0]      mode_q, bresp_q, rresp_q;
  logic            aw_ok, w_ok, tmo_hit, tmo_evt, chk_err, add_err;
  logic [TW-1:0]   tmr;
  logic [AW-1:0]   reg_addr;

  // Expected word for the current register; arithmetic wraps at 2^DW.
  always_comb begin
    pattern = seed_q;
    case (mode_q)
      2'd1:    pattern = seed_q + DW'(idx);
      2'd2:    pattern = DW'(1) << idx[BW-1:0];
      2'd3:    pattern = ~(seed_q + DW'(idx));
      default: pattern = seed_q;
    endcase
  end

  assign reg_addr      = BASE_ADDR + AW'(idx) * AW'(SW);
  assign M_AXI_AWADDR  = reg_addr;
  assign M_AXI_ARADDR  = reg_addr;
  assign M_AXI_WDATA   = pattern;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;

  assign tmo_hit = (tmr == TW'(TIMEOUT_CYCLES - 1));
  assign chk_err = (bresp_q != 2'b00) || (rresp_q != 2'b00) || (rdata_q != pattern);
  assign add_err = ((state == S_CHECK) && chk_err) || tmo_evt;

  // Next state and channel controls; a timeout in a wait state aborts to FIN.
  always_comb begin
    state_nxt     = state;
    tmo_evt       = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (state)
      S_IDLE: if (start && !done) state_nxt = S_WR;
      S_WR: begin
        M_AXI_AWVALID = !aw_ok;
        M_AXI_WVALID  = !w_ok;
        if ((aw_ok || M_AXI_AWREADY) && (w_ok || M_AXI_WREADY)) state_nxt = S_WR_RESP;
        else if (tmo_hit) begin state_nxt = S_FIN; tmo_evt = 1'b1; end
      end
      S_WR_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_nxt = S_RD;
        else if (tmo_hit) begin state_nxt = S_FIN; tmo_evt = 1'b1; end
      end
      S_RD: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_nxt = S_RD_DATA;
        else if (tmo_hit) begin state_nxt = S_FIN; tmo_evt = 1'b1; end
      end
      S_RD_DATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) state_nxt = S_CHECK;
        else if (tmo_hit) begin state_nxt = S_FIN; tmo_evt = 1'b1; end
      end
      S_CHECK: state_nxt = (idx == 8'(NUM_REGS - 1)) ? S_FIN : S_NEXT;
      S_NEXT:  state_nxt = S_WR;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, per-state wait counter, captured responses and run status.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= S_IDLE; tmr <= '0; idx <= '0;
      seed_q <= '0; mode_q <= '0; rdata_q <= '0; bresp_q <= '0; rresp_q <= '0;
      aw_ok <= 1'b0; w_ok <= 1'b0;
      busy <= 1'b0; done <= 1'b0; pass <= 1'b0; timeout <= 1'b0;
      err_count <= '0; first_err_idx <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= (state_nxt != state) ? '0 : tmr + TW'(1);
      done  <= 1'b0;
      case (state)
        S_IDLE: if (start && !done) begin
          seed_q <= seed; mode_q <= pattern_mode; idx <= '0;
          err_count <= '0; first_err_idx <= '0; pass <= 1'b0; timeout <= 1'b0;
          busy <= 1'b1; aw_ok <= 1'b0; w_ok <= 1'b0;
        end
        S_WR: begin
          if (M_AXI_AWVALID && M_AXI_AWREADY) aw_ok <= 1'b1;
          if (M_AXI_WVALID && M_AXI_WREADY)   w_ok  <= 1'b1;
        end
        S_WR_RESP: if (M_AXI_BVALID) bresp_q <= M_AXI_BRESP;
        S_RD_DATA: if (M_AXI_RVALID) begin rdata_q <= M_AXI_RDATA; rresp_q <= M_AXI_RRESP; end
        S_NEXT: begin idx <= idx + 8'd1; aw_ok <= 1'b0; w_ok <= 1'b0; end
        S_FIN: begin busy <= 1'b0; done <= 1'b1; pass <= (err_count == 8'd0) && !timeout; end
        default: ;
      endcase
      if (add_err) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (err_count == 8'd0)  first_err_idx <= idx;
      end
      if (tmo_evt) timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_lite_regtest_master.sv
`timescale 1ns/1ps
// Directed bench: two masters (4 and 8 registers) each talking to a small RAM slave
// with knobs for ready delays, a stuck data bit, SLVERR reads and a dead AR channel.
module tb_axi_lite_regtest_master;
  logic tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  logic rst_n = 1'b0;
  int   errors = 0, checks = 0;

  logic        start[2];
  logic [1:0]  mode;
  logic [31:0] seed;
  logic        busy[2], done[2], pass[2], tmo[2];
  logic [7:0]  errc[2], fidx[2];
  logic [31:0] awaddr[2], wdata[2], araddr[2], rdata[2];
  logic [2:0]  awprot[2], arprot[2];
  logic [3:0]  wstrb[2];
  logic [1:0]  bresp[2], rresp[2];
  logic        awvalid[2], awready[2], wvalid[2], wready[2], bvalid[2], bready[2];
  logic        arvalid[2], arready[2], rvalid[2], rready[2];

  // Slave knobs
  int          aw_delay = 0, w_delay = 0;
  logic [31:0] stuck_mask = 32'hFFFF_FFFF;
  logic        rresp_err = 1'b0, ar_never = 1'b0, clr_mon = 1'b0;

  // Slave state and monitors
  int          aw_wait[2], w_wait[2];
  logic        aw_got[2], w_got[2], ar_got[2];
  logic [31:0] aw_q[2], w_q[2], ar_q[2];
  logic [31:0] mem[2][16];
  int          aw_hs_n[2], w_hs_n[2], aw_viol[2], w_viol[2], arv_n[2];

  axi_lite_regtest_master #(.NUM_REGS(4), .TIMEOUT_CYCLES(16)) u_dut_a (
    .ACLK(tb_ACLK), .ARESETN(rst_n), .start(start[0]), .pattern_mode(mode), .seed(seed),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timeout(tmo[0]),
    .err_count(errc[0]), .first_err_idx(fidx[0]),
    .M_AXI_AWADDR(awaddr[0]), .M_AXI_AWPROT(awprot[0]), .M_AXI_AWVALID(awvalid[0]), .M_AXI_AWREADY(awready[0]),
    .M_AXI_WDATA(wdata[0]), .M_AXI_WSTRB(wstrb[0]), .M_AXI_WVALID(wvalid[0]), .M_AXI_WREADY(wready[0]),
    .M_AXI_BRESP(bresp[0]), .M_AXI_BVALID(bvalid[0]), .M_AXI_BREADY(bready[0]),
    .M_AXI_ARADDR(araddr[0]), .M_AXI_ARPROT(arprot[0]), .M_AXI_ARVALID(arvalid[0]), .M_AXI_ARREADY(arready[0]),
    .M_AXI_RDATA(rdata[0]), .M_AXI_RRESP(rresp[0]), .M_AXI_RVALID(rvalid[0]), .M_AXI_RREADY(rready[0]));

  axi_lite_regtest_master #(.NUM_REGS(8), .TIMEOUT_CYCLES(256)) u_dut_b (
    .ACLK(tb_ACLK), .ARESETN(rst_n), .start(start[1]), .pattern_mode(mode), .seed(seed),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timeout(tmo[1]),
    .err_count(errc[1]), .first_err_idx(fidx[1]),
    .M_AXI_AWADDR(awaddr[1]), .M_AXI_AWPROT(awprot[1]), .M_AXI_AWVALID(awvalid[1]), .M_AXI_AWREADY(awready[1]),
    .M_AXI_WDATA(wdata[1]), .M_AXI_WSTRB(wstrb[1]), .M_AXI_WVALID(wvalid[1]), .M_AXI_WREADY(wready[1]),
    .M_AXI_BRESP(bresp[1]), .M_AXI_BVALID(bvalid[1]), .M_AXI_BREADY(bready[1]),
    .M_AXI_ARADDR(araddr[1]), .M_AXI_ARPROT(arprot[1]), .M_AXI_ARVALID(arvalid[1]), .M_AXI_ARREADY(arready[1]),
    .M_AXI_RDATA(rdata[1]), .M_AXI_RRESP(rresp[1]), .M_AXI_RVALID(rvalid[1]), .M_AXI_RREADY(rready[1]));

  // Slave ready/response levels
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      awready[k] = (aw_wait[k] >= aw_delay);
      wready[k]  = (w_wait[k] >= w_delay);
      arready[k] = !ar_never;
      bresp[k]   = 2'b00;
      rresp[k]   = rresp_err ? 2'b10 : 2'b00;
    end
  end

  // RAM slave: B one cycle after both AW and W are in, R one cycle after AR
  always @(posedge tb_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        aw_wait[k] <= 0; w_wait[k] <= 0; aw_got[k] <= 1'b0; w_got[k] <= 1'b0; ar_got[k] <= 1'b0;
        aw_q[k] <= '0; w_q[k] <= '0; ar_q[k] <= '0; bvalid[k] <= 1'b0; rvalid[k] <= 1'b0; rdata[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (awvalid[k] && awready[k]) begin aw_got[k] <= 1'b1; aw_q[k] <= awaddr[k]; aw_wait[k] <= 0; end
        else if (awvalid[k]) aw_wait[k] <= aw_wait[k] + 1;
        if (wvalid[k] && wready[k]) begin w_got[k] <= 1'b1; w_q[k] <= wdata[k]; w_wait[k] <= 0; end
        else if (wvalid[k]) w_wait[k] <= w_wait[k] + 1;
        if (bvalid[k] && bready[k]) bvalid[k] <= 1'b0;
        if (aw_got[k] && w_got[k]) begin
          mem[k][aw_q[k][5:2]] <= w_q[k] & stuck_mask;
          bvalid[k] <= 1'b1; aw_got[k] <= 1'b0; w_got[k] <= 1'b0;
        end
        if (arvalid[k] && arready[k]) begin ar_got[k] <= 1'b1; ar_q[k] <= araddr[k]; end
        if (rvalid[k] && rready[k]) rvalid[k] <= 1'b0;
        if (ar_got[k]) begin rvalid[k] <= 1'b1; rdata[k] <= mem[k][ar_q[k][5:2]]; ar_got[k] <= 1'b0; end
      end
    end
  end

  // Handshake monitors, cleared at each start
  always @(posedge tb_ACLK) begin
    for (int k = 0; k < 2; k++) begin
      if (clr_mon) begin
        aw_hs_n[k] <= 0; w_hs_n[k] <= 0; aw_viol[k] <= 0; w_viol[k] <= 0; arv_n[k] <= 0;
      end else begin
        if (awvalid[k] && awready[k]) aw_hs_n[k] <= aw_hs_n[k] + 1;
        if (wvalid[k] && wready[k])   w_hs_n[k]  <= w_hs_n[k] + 1;
        if (awvalid[k] && aw_got[k])  aw_viol[k] <= aw_viol[k] + 1;
        if (wvalid[k] && w_got[k])    w_viol[k]  <= w_viol[k] + 1;
        if (arvalid[k])               arv_n[k]   <= arv_n[k] + 1;
      end
    end
  end

  function automatic logic [120:0] outs(int k);
    return {busy[k], done[k], pass[k], tmo[k], errc[k], fidx[k],
            awvalid[k], wvalid[k], bready[k], arvalid[k], rready[k], awaddr[k], wdata[k], araddr[k]};
  endfunction

  task automatic pulse_start(input int k, input logic [1:0] m, input logic [31:0] s);
    @(negedge tb_ACLK); mode = m; seed = s; start[k] = 1'b1; clr_mon = 1'b1;
    @(negedge tb_ACLK); start[k] = 1'b0; clr_mon = 1'b0;
  endtask

  // n counts clock edges since the edge that sampled start (that edge is 1)
  task automatic wait_done(input int k, input int n0, output int n);
    n = n0;
    while (done[k] !== 1'b1 && n < 400) begin @(negedge tb_ACLK); n++; end
  endtask

  task automatic test_reset;
    start[0] = 1'b0; start[1] = 1'b0; mode = 2'd0; seed = '0; rst_n = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    for (int k = 0; k < 2; k++) begin
      checks++; if (outs(k) !== '0) begin errors++; $display("FAIL reset_outs[%0d]: got %h exp 0", k, outs(k)); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait;
    int cyc;
    pulse_start(0, 2'd1, 32'h0101FFFF);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b exp 1", busy[0]); end
    wait_done(0, 1, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL t1_latency: got %0d exp 33", cyc); end
    checks++; if ({pass[0], tmo[0], errc[0], fidx[0], busy[0]} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
      errors++; $display("FAIL t1_status: pass=%b tmo=%b err=%0d fidx=%0d busy=%b exp 1 0 0 0 0",
                         pass[0], tmo[0], errc[0], fidx[0], busy[0]); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[0][i] !== 32'h0101FFFF + 32'(i)) begin
        errors++; $display("FAIL t1_mem[%0d]: got %h exp %h", i, mem[0][i], 32'h0101FFFF + 32'(i)); end
    end
    @(negedge tb_ACLK);
    checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL t1_done_pulse: got %b exp 0", done[0]); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    pulse_start(0, 2'd0, 32'h12345678);
    repeat (9) @(negedge tb_ACLK);
    seed = 32'hDEAD0000; start[0] = 1'b1;
    @(negedge tb_ACLK); start[0] = 1'b0;
    wait_done(0, 11, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_latency: got %0d exp 33", cyc); end
    checks++; if (mem[0][3] !== 32'h12345678 || pass[0] !== 1'b1) begin
      errors++; $display("FAIL b2b_data: mem3=%h pass=%b exp 12345678 1", mem[0][3], pass[0]); end
    start[0] = 1'b1; seed = 32'h0BAD0BAD;
    @(negedge tb_ACLK); start[0] = 1'b0;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_start_on_done: busy=%b exp 0", busy[0]); end
  endtask

  task automatic test_ready_skew;
    int cyc;
    aw_delay = 3; w_delay = 0;
    pulse_start(0, 2'd0, 32'hA5A5A5A5);
    wait_done(0, 1, cyc);
    checks++; if (cyc !== 45 || pass[0] !== 1'b1) begin
      errors++; $display("FAIL t2a_run: cycles=%0d pass=%b exp 45 1", cyc, pass[0]); end
    checks++; if ({aw_hs_n[0], w_hs_n[0], w_viol[0]} !== {32'd4, 32'd4, 32'd0}) begin
      errors++; $display("FAIL t2a_hs: aw=%0d w=%0d wviol=%0d exp 4 4 0", aw_hs_n[0], w_hs_n[0], w_viol[0]); end
    aw_delay = 0; w_delay = 3;
    pulse_start(0, 2'd3, 32'h0000000F);
    wait_done(0, 1, cyc);
    checks++; if (cyc !== 45 || pass[0] !== 1'b1) begin
      errors++; $display("FAIL t2b_run: cycles=%0d pass=%b exp 45 1", cyc, pass[0]); end
    checks++; if ({aw_hs_n[0], w_hs_n[0], aw_viol[0]} !== {32'd4, 32'd4, 32'd0}) begin
      errors++; $display("FAIL t2b_hs: aw=%0d w=%0d awviol=%0d exp 4 4 0", aw_hs_n[0], w_hs_n[0], aw_viol[0]); end
    checks++; if (mem[0][3] !== 32'hFFFFFFED) begin
      errors++; $display("FAIL t2b_mem3: got %h exp FFFFFFED", mem[0][3]); end
    w_delay = 0;
  endtask

  task automatic test_stuck_bit;
    int cyc;
    stuck_mask = 32'hFFFF_FFEF;
    pulse_start(1, 2'd2, 32'h0);
    wait_done(1, 1, cyc);
    checks++; if (cyc !== 65) begin errors++; $display("FAIL t3_latency: got %0d exp 65", cyc); end
    checks++; if ({errc[1], fidx[1], pass[1], tmo[1]} !== {8'd1, 8'd4, 1'b0, 1'b0}) begin
      errors++; $display("FAIL t3_status: err=%0d fidx=%0d pass=%b tmo=%b exp 1 4 0 0",
                         errc[1], fidx[1], pass[1], tmo[1]); end
    stuck_mask = 32'hFFFF_FFFF;
  endtask

  task automatic test_rresp_err;
    int cyc;
    rresp_err = 1'b1;
    pulse_start(0, 2'd1, 32'h0);
    wait_done(0, 1, cyc);
    checks++; if ({errc[0], fidx[0], pass[0]} !== {8'd4, 8'd0, 1'b0} || cyc !== 33) begin
      errors++; $display("FAIL t4_status: err=%0d fidx=%0d pass=%b cycles=%0d exp 4 0 0 33",
                         errc[0], fidx[0], pass[0], cyc); end
    rresp_err = 1'b0;
  endtask

  task automatic test_timeout;
    int cyc;
    ar_never = 1'b1;
    pulse_start(0, 2'd0, 32'h5555AAAA);
    wait_done(0, 1, cyc);
    checks++; if (cyc !== 21) begin errors++; $display("FAIL t5_latency: got %0d exp 21", cyc); end
    checks++; if (arv_n[0] !== 16) begin errors++; $display("FAIL t5_arvalid_cycles: got %0d exp 16", arv_n[0]); end
    checks++; if ({tmo[0], pass[0], busy[0], errc[0], fidx[0], arvalid[0]} !== {1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0}) begin
      errors++; $display("FAIL t5_status: tmo=%b pass=%b busy=%b err=%0d fidx=%0d arvalid=%b exp 1 0 0 1 0 0",
                         tmo[0], pass[0], busy[0], errc[0], fidx[0], arvalid[0]); end
    ar_never = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int n, dn, cyc;
    pulse_start(0, 2'd1, 32'h100);
    n = 0;
    while (bready[0] !== 1'b1 && n < 20) begin @(negedge tb_ACLK); n++; end
    checks++; if (bready[0] !== 1'b1 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL t6_reach_wr_resp: bready=%b busy=%b exp 1 1", bready[0], busy[0]); end
    rst_n = 1'b0;
    #1;
    checks++; if (outs(0) !== '0) begin errors++; $display("FAIL t6_outs_in_reset: got %h exp 0", outs(0)); end
    repeat (2) @(negedge tb_ACLK);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin @(negedge tb_ACLK); if (done[0] === 1'b1) dn++; end
    checks++; if (dn !== 0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL t6_no_done: done_cycles=%0d busy=%b exp 0 0", dn, busy[0]); end
    pulse_start(0, 2'd1, 32'h200);
    checks++; if ({awvalid[0], awaddr[0], wdata[0]} !== {1'b1, 32'h0, 32'h200}) begin
      errors++; $display("FAIL t6_restart_i0: awvalid=%b awaddr=%h wdata=%h exp 1 0 200",
                         awvalid[0], awaddr[0], wdata[0]); end
    wait_done(0, 1, cyc);
    checks++; if (cyc !== 33 || pass[0] !== 1'b1 || mem[0][0] !== 32'h200 || mem[0][3] !== 32'h203) begin
      errors++; $display("FAIL t6_rerun: cycles=%0d pass=%b mem0=%h mem3=%h exp 33 1 200 203",
                         cyc, pass[0], mem[0][0], mem[0][3]); end
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_back_to_back;
    test_ready_skew;
    test_stuck_bit;
    test_rresp_err;
    test_timeout;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
